instr_fetch_unit: RTL and testbench

Multicycle instruction fetch stage directly downstream of the program counter. When the control FSM enters its fetch state, the block takes the current PC and issues one read to instruction memory with a req/ready handshake. It latches the returned word into the instruction register and presents that word, plus PC+4, to decode and next-PC logic. Misaligned PCs and memory that never answers are reported as faults instead of hanging the processor.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding, fault causes and the reset
// instruction value.
package mips_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: one req/ready read per fetch_start, with
// misalignment and memory-timeout faults reported as one-cycle pulses.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [7:0] tmo_cnt;
  logic       tmo_expired;

  assign tmo_expired = (tmo_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (fetch_start) state_nx = word_aligned(pc_in) ? ST_WAIT : ST_FAULT;
      ST_WAIT:
        // ready takes priority over a timeout expiring in the same cycle
        if (imem_ready)       state_nx = ST_DONE;
        else if (tmo_expired) state_nx = ST_FAULT;
      ST_DONE:  state_nx = ST_IDLE;
      ST_FAULT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next-state value so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= NOP_INSTR;
      pc_plus4    <= 32'h0000_0004;
      fetch_busy  <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      state       <= state_nx;
      imem_req    <= (state_nx == ST_WAIT);
      fetch_busy  <= (state_nx != ST_IDLE);
      fetch_done  <= (state_nx == ST_DONE);
      fetch_fault <= (state_nx == ST_FAULT);
      case (state)
        ST_IDLE:
          if (fetch_start) begin
            imem_addr   <= pc_in;
            tmo_cnt     <= '0;
            fault_cause <= word_aligned(pc_in) ? FC_NONE : FC_MISALIGN;
          end
        ST_WAIT:
          if (imem_ready) begin
            instr    <= imem_rdata;
            pc_plus4 <= imem_addr + 32'd4;
          end else if (tmo_expired) begin
            fault_cause <= FC_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table with a scoreboard
// queue, plus hand-written reset and mid-fetch sequences.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  instr_fetch_unit #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          ready_cyc;   // request cycle in which ready is given; 0 = never
    logic        exp_done;    // 1 = done pulse, 0 = fault pulse
    logic [1:0]  exp_cause;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    int          exp_lat;     // edges from accepting edge to visible pulse
    int          exp_req;     // cycles with imem_req high
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " imem_req"},    32'(imem_req),    32'd0);
    chk({tag, " imem_addr"},   imem_addr,        32'd0);
    chk({tag, " instr"},       instr,            NOP_INSTR);
    chk({tag, " pc_plus4"},    pc_plus4,         32'd4);
    chk({tag, " fetch_busy"},  32'(fetch_busy),  32'd0);
    chk({tag, " fetch_done"},  32'(fetch_done),  32'd0);
    chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, " fault_cause"}, 32'(fault_cause), 32'(FC_NONE));
  endtask

  task automatic run_fetch(input vec_t v, input int idx);
    vec_t exp;
    int   req_cnt;
    int   lat;
    bit   seen;
    bit   got_done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    pc_in       = v.pc;
    fetch_start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    fetch_start = 1'b0;
    req_cnt  = 0;
    lat      = 0;
    seen     = 1'b0;
    got_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (fetch_done || fetch_fault) begin
        seen     = 1'b1;
        got_done = fetch_done;
        lat      = c - 1;
        break;
      end
      chk({tag, " busy"}, 32'(fetch_busy), 32'd1);
      if (imem_req) begin
        req_cnt++;
        chk({tag, " imem_addr"}, imem_addr, v.pc);
        imem_ready = (req_cnt == v.ready_cyc);
        imem_rdata = imem_ready ? v.rdata : $urandom;
      end else begin
        imem_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    exp = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s pulse: got none within 20 cycles, expected done/fault", tag);
    end else begin
      chk({tag, " done"},     32'(fetch_done),  32'(exp.exp_done));
      chk({tag, " fault"},    32'(fetch_fault), 32'(!exp.exp_done));
      chk({tag, " kind"},     32'(got_done),    32'(exp.exp_done));
      chk({tag, " latency"},  32'(lat),         32'(exp.exp_lat));
      chk({tag, " req_cyc"},  32'(req_cnt),     32'(exp.exp_req));
      chk({tag, " instr"},    instr,            exp.exp_instr);
      chk({tag, " pc_plus4"}, pc_plus4,         exp.exp_pc4);
      chk({tag, " cause"},    32'(fault_cause), 32'(exp.exp_cause));
    end
    @(posedge clk); #1;
    chk({tag, " done_off"},   32'(fetch_done),  32'd0);
    chk({tag, " fault_off"},  32'(fetch_fault), 32'd0);
    chk({tag, " busy_off"},   32'(fetch_busy),  32'd0);
    chk({tag, " cause_held"}, 32'(fault_cause), 32'(exp.exp_cause));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pc            rdata         rdy done cause        instr         pc+4          lat req
    vecs[0] = '{32'h0000_0000, 32'h8C22_0004, 1, 1'b1, FC_NONE,     32'h8C22_0004, 32'h0000_0004, 1, 1};
    vecs[1] = '{32'h0000_0040, 32'h0022_1820, 3, 1'b1, FC_NONE,     32'h0022_1820, 32'h0000_0044, 3, 3};
    vecs[2] = '{32'h0000_0042, 32'h1111_1111, 0, 1'b0, FC_MISALIGN, 32'h0022_1820, 32'h0000_0044, 0, 0};
    vecs[3] = '{32'h0000_0100, 32'h2222_2222, 0, 1'b0, FC_TIMEOUT,  32'h0022_1820, 32'h0000_0044, 4, 4};
    vecs[4] = '{32'h0000_0200, 32'h1234_5678, 1, 1'b1, FC_NONE,     32'h1234_5678, 32'h0000_0204, 1, 1};
    vecs[5] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 2, 1'b1, FC_NONE,     32'hDEAD_BEEF, 32'h0000_0000, 2, 2};
    vecs[6] = '{32'h0000_0080, 32'hCAFE_F00D, 4, 1'b1, FC_NONE,     32'hCAFE_F00D, 32'h0000_0084, 4, 4};
    vecs[7] = '{32'h0000_0003, 32'h3333_3333, 0, 1'b0, FC_MISALIGN, 32'hCAFE_F00D, 32'h0000_0084, 0, 0};

    reset       = 1'b1;
    fetch_start = 1'b0;
    pc_in       = '0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_fetch(vecs[i], i);

    // Reset during the second request cycle; a start while busy must be ignored.
    pc_in       = 32'h0000_0040;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    chk("midrst req1", 32'(imem_req), 32'd1);
    pc_in       = 32'h0000_0013;
    fetch_start = 1'b1;
    imem_ready  = 1'b0;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    chk("midrst req2",      32'(imem_req),    32'd1);
    chk("midrst addr_kept", imem_addr,        32'h0000_0040);
    chk("midrst cause",     32'(fault_cause), 32'(FC_NONE));
    chk("midrst nofault",   32'(fetch_fault), 32'd0);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    chk_reset_values("midrst");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d pulse", c), 32'({fetch_done, fetch_fault, fetch_busy, imem_req}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
